wrr_arbiter: RTL and testbench

Parametrised weighted round-robin arbiter with registered grant outputs, per-port runtime weights and three grant-hold modes. It arbitrates PORTS requesters for one shared resource, such as a bus, a mux select or a memory port. It is the next generation of the team's plain priority/round-robin arbiter: it adds burst weighting and credit-based hold, so one requester cannot monopolise the resource.

---
 rtl/wrr_arbiter.sv | 128 ++++++++++++
 tb/tb_wrr_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: one-hot registered grant, per-port runtime
// weights loaded as burst credit, and a selectable grant-hold mode.
module wrr_arbiter #(
  parameter int    PORTS        = 4,
  parameter int    WEIGHT_W     = 4,
  parameter string BLOCK        = "REQUEST",
  parameter string LSB_PRIORITY = "LOW"
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PORTS-1:0]          request,
  input  logic [PORTS-1:0]          acknowledge,
  input  logic [PORTS*WEIGHT_W-1:0] weight,
  output logic [PORTS-1:0]          grant,
  output logic                      grant_valid,
  output logic [$clog2(PORTS)-1:0]  grant_encoded
);

  localparam int IDX_W = $clog2(PORTS);

  typedef enum logic [1:0] {HOLD_NONE, HOLD_REQUEST, HOLD_ACK} hold_e;
  localparam hold_e HOLD = (BLOCK == "NONE")        ? HOLD_NONE :
                           (BLOCK == "ACKNOWLEDGE") ? HOLD_ACK  : HOLD_REQUEST;
  localparam bit DIR_LOW = (LSB_PRIORITY != "HIGH");

  // The first search after reset must begin at port 0 (LOW) or PORTS-1 (HIGH),
  // so the pointer rests one step "behind" that port.
  localparam logic [IDX_W-1:0] PTR_RST = DIR_LOW ? IDX_W'(PORTS - 1) : '0;

  typedef enum logic {IDLE, GRANTED} state_e;

  state_e               state_q, state_d;
  logic [PORTS-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [WEIGHT_W-1:0]  cnt_q, cnt_d;

  logic                 rearb;
  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [WEIGHT_W-1:0]  win_weight;

  // Round-robin search starting just after `start`, with `start` itself last.
  function automatic logic [IDX_W:0] rr_search(input logic [IDX_W-1:0] start,
                                               input logic [PORTS-1:0] req);
    logic             found;
    logic [IDX_W-1:0] idx;
    int               pos;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= PORTS; k++) begin
      if (DIR_LOW) pos = (int'(start) + k) % PORTS;
      else         pos = (int'(start) - k + PORTS) % PORTS;
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = IDX_W'(pos);
      end
    end
    return {found, idx};
  endfunction

  // Next-state: decide whether the current owner releases, then re-arbitrate
  // on the same edge so consecutive grants have no dead cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the branches below leaves it unassigned (which would infer a latch).
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    rearb   = 1'b0;

    {win_found, win_idx} = rr_search(ptr_q, request);
    win_weight = weight[int'(win_idx)*WEIGHT_W +: WEIGHT_W];

    case (state_q)
      IDLE: rearb = 1'b1;
      GRANTED: begin
        // While granted, ptr_q is the owner's index.
        if (HOLD == HOLD_NONE) begin
          rearb = 1'b1;
        end else if (HOLD == HOLD_REQUEST) begin
          if (!request[ptr_q] || cnt_q == WEIGHT_W'(1)) rearb = 1'b1;
          else                                          cnt_d = cnt_q - WEIGHT_W'(1);
        end else if (acknowledge[ptr_q]) begin
          if (!request[ptr_q] || cnt_q == WEIGHT_W'(1)) rearb = 1'b1;
          else                                          cnt_d = cnt_q - WEIGHT_W'(1);
        end
      end
      default: rearb = 1'b1;
    endcase

    if (rearb) begin
      if (win_found) begin
        state_d = GRANTED;
        grant_d = PORTS'(1) << win_idx;
        ptr_d   = win_idx;
        // A zero weight still buys one grant cycle.
        cnt_d   = (win_weight == '0) ? WEIGHT_W'(1) : win_weight;
      end else begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant         = grant_q;
  assign grant_valid   = (state_q == GRANTED);
  assign grant_encoded = (state_q == GRANTED) ? ptr_q : '0;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Bench for wrr_arbiter: four instances (NONE/LOW, NONE/HIGH, REQUEST/LOW,
// ACKNOWLEDGE/LOW) share one stimulus stream; a burst-usage reference model
// predicts every output each cycle, and directed scenarios add fixed values.
module tb_wrr_arbiter;

  localparam int N = 4;

  logic          clk;
  logic          rst;
  logic [3:0]    request;
  logic [3:0]    acknowledge;
  logic [15:0]   weight;

  logic [3:0]    dut_grant [N];
  logic          dut_valid [N];
  logic [1:0]    dut_enc   [N];

  int n_checks = 0;
  int n_errors = 0;

  // Reference-model state per instance: owner (-1 = none), last winner,
  // grant cycles/acks already consumed and the weight captured at grant.
  int mode_of [N] = '{0, 0, 1, 2};   // 0 NONE, 1 REQUEST, 2 ACKNOWLEDGE
  bit low_of  [N] = '{1, 0, 1, 1};
  int m_owner [N];
  int m_last  [N];
  int m_used  [N];
  int m_wt    [N];

  wrr_arbiter #(.PORTS(4), .WEIGHT_W(4), .BLOCK("NONE"), .LSB_PRIORITY("LOW")) u_none_lo (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge), .weight(weight),
    .grant(dut_grant[0]), .grant_valid(dut_valid[0]), .grant_encoded(dut_enc[0]));
  wrr_arbiter #(.PORTS(4), .WEIGHT_W(4), .BLOCK("NONE"), .LSB_PRIORITY("HIGH")) u_none_hi (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge), .weight(weight),
    .grant(dut_grant[1]), .grant_valid(dut_valid[1]), .grant_encoded(dut_enc[1]));
  wrr_arbiter #(.PORTS(4), .WEIGHT_W(4), .BLOCK("REQUEST"), .LSB_PRIORITY("LOW")) u_req (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge), .weight(weight),
    .grant(dut_grant[2]), .grant_valid(dut_valid[2]), .grant_encoded(dut_enc[2]));
  wrr_arbiter #(.PORTS(4), .WEIGHT_W(4), .BLOCK("ACKNOWLEDGE"), .LSB_PRIORITY("LOW")) u_ack (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge), .weight(weight),
    .grant(dut_grant[3]), .grant_valid(dut_valid[3]), .grant_encoded(dut_enc[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // First requester in round-robin order after `last`.
  function automatic int pick(input int last, input bit low, input logic [3:0] req);
    int p;
    for (int k = 1; k <= N; k++) begin
      p = low ? (last + k) % N : (last - k + 2 * N) % N;
      if (req[p]) return p;
    end
    return -1;
  endfunction

  // Apply one clock edge of the arbitration rules to model instance i.
  task automatic model_step(input int i);
    bit rel;
    int w;
    int p;
    if (rst) begin
      m_owner[i] = -1;
      m_last[i]  = low_of[i] ? N - 1 : 0;
      m_used[i]  = 0;
      return;
    end
    rel = 1'b0;
    if (m_owner[i] < 0) begin
      rel = 1'b1;
    end else begin
      case (mode_of[i])
        0: rel = 1'b1;
        1: if (!request[m_owner[i]] || m_used[i] + 1 >= m_wt[i]) rel = 1'b1;
           else m_used[i]++;
        default:
          if (acknowledge[m_owner[i]]) begin
            if (!request[m_owner[i]] || m_used[i] + 1 >= m_wt[i]) rel = 1'b1;
            else m_used[i]++;
          end
      endcase
    end
    if (rel) begin
      p = pick(m_last[i], low_of[i], request);
      if (p >= 0) begin
        w          = int'(weight[p*4 +: 4]);
        m_owner[i] = p;
        m_last[i]  = p;
        m_used[i]  = 0;
        m_wt[i]    = (w == 0) ? 1 : w;
      end else begin
        m_owner[i] = -1;
      end
    end
  endtask

  // One clock: advance the model with the inputs present at the edge, then
  // compare every instance shortly after the edge.
  task automatic tick();
    logic [3:0] eg;
    @(posedge clk);
    for (int i = 0; i < N; i++) model_step(i);
    #1;
    for (int i = 0; i < N; i++) begin
      eg = (m_owner[i] < 0) ? 4'b0000 : 4'(1 << m_owner[i]);
      check($sformatf("model_grant%0d", i), 32'(dut_grant[i]), 32'(eg));
      check($sformatf("model_valid%0d", i), 32'(dut_valid[i]), 32'(m_owner[i] >= 0));
      check($sformatf("model_enc%0d", i), 32'(dut_enc[i]),
            32'((m_owner[i] < 0) ? 0 : m_owner[i]));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_lo [4];
    logic [3:0] exp_hi [4];
    logic [3:0] exp_w3 [8];
    logic [3:0] exp_w0 [4];
    exp_lo = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_hi = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
    exp_w3 = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
    exp_w0 = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};

    rst = 1'b1; request = 4'hF; acknowledge = 4'h0; weight = 16'h1111;

    // Reset with everyone requesting, then first grants.
    tick();
    check("rst_grant", 32'(dut_grant[0]), 32'h0);
    check("rst_valid", 32'(dut_valid[0]), 32'h0);
    check("rst_enc",   32'(dut_enc[0]),   32'h0);
    rst = 1'b0;
    tick();
    check("first_lo_grant", 32'(dut_grant[0]), 32'h1);
    check("first_lo_enc",   32'(dut_enc[0]),   32'h0);
    check("first_hi_grant", 32'(dut_grant[1]), 32'h8);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("none_lo_seq%0d", k), 32'(dut_grant[0]), 32'(exp_lo[k]));
      check($sformatf("none_hi_seq%0d", k), 32'(dut_grant[1]), 32'(exp_hi[k]));
    end

    // REQUEST mode, port0 weight 3 vs port1 weight 1.
    weight = 16'h0013; request = 4'b0011;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("req_w3_seq%0d", k), 32'(dut_grant[2]), 32'(exp_w3[k]));
    end

    // Zero weight on port0 behaves as weight 1.
    weight = 16'h0010;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("req_w0_seq%0d", k), 32'(dut_grant[2]), 32'(exp_w0[k]));
    end

    // Request drop mid-burst hands over on the same edge.
    weight = 16'h0013;
    do_reset();
    tick();
    check("drop_before", 32'(dut_grant[2]), 32'h1);
    request = 4'b0010;
    tick();
    check("drop_after",  32'(dut_grant[2]), 32'h2);
    check("drop_valid",  32'(dut_valid[2]), 32'h1);

    // ACKNOWLEDGE mode, port0 weight 2 against port2.
    weight = 16'h0002; request = 4'b0101;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("ack_hold%0d", k), 32'(dut_grant[3]), 32'h1);
    end
    acknowledge = 4'b0100;
    tick();
    check("ack_other_ignored", 32'(dut_grant[3]), 32'h1);
    acknowledge = 4'b0001;
    tick();
    check("ack_first", 32'(dut_grant[3]), 32'h1);
    acknowledge = 4'b0000;
    tick();
    check("ack_gap", 32'(dut_grant[3]), 32'h1);
    acknowledge = 4'b0001;
    tick();
    check("ack_second_grant", 32'(dut_grant[3]), 32'h4);
    check("ack_second_enc",   32'(dut_enc[3]),   32'h2);
    acknowledge = 4'b0000;

    // Reset in the middle of a burst.
    weight = 16'h0013; request = 4'b0011;
    do_reset();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrst_grant", 32'(dut_grant[2]), 32'h0);
    check("midrst_valid", 32'(dut_valid[2]), 32'h0);
    rst = 1'b0; request = 4'hF;
    tick();
    check("midrst_regrant", 32'(dut_grant[2]), 32'h1);

    // Randomised traffic against the model.
    for (int c = 0; c < 600; c++) begin
      rst         = ($urandom_range(0, 59) == 0);
      request     = 4'($urandom);
      acknowledge = 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 7) == 0) weight = 16'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
